// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: ID/EX/MEM status in, stage enables out.
// fsm_state encoding: 0 RUN, 1 RAW, 2 FLUSH, 3 FREEZE.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
   logic             id_valid;
   logic [5:0]       id_opcode;
   logic [2:0]       id_ctrl_acum;
   logic             ex_branch_taken;
   logic             mem_busy;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic [CNT_W-1:0] stall_cnt;
   logic [1:0]       fsm_state;

   modport master (
      output id_valid, id_opcode, id_ctrl_acum, ex_branch_taken, mem_busy,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_cnt, fsm_state
   );

   modport slave (
      input  id_valid, id_opcode, id_ctrl_acum, ex_branch_taken, mem_busy,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_cnt, fsm_state
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage accumulator CPU: RAW scoreboard
// stalls, JMP/branch flushes, memory freeze and a saturating stall counter.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {RUN = 2'd0, RAW = 2'd1, FLUSH = 2'd2, FREEZE = 2'd3} state_t;

   // Opcode map (instr[15:10]); encodings 38..63 are unassigned.
   localparam logic [5:0] OP_STA   = 6'd3,  OP_STB   = 6'd4;
   localparam logic [5:0] OP_ADDA  = 6'd7,  OP_ADDB  = 6'd8,  OP_ADDCA = 6'd9,  OP_ADDCB = 6'd10;
   localparam logic [5:0] OP_SUBA  = 6'd11, OP_SUBB  = 6'd12, OP_SUBCA = 6'd13, OP_SUBCB = 6'd14;
   localparam logic [5:0] OP_ANDA  = 6'd15, OP_ANDB  = 6'd16, OP_ANDCA = 6'd17, OP_ANDCB = 6'd18;
   localparam logic [5:0] OP_ORA   = 6'd19, OP_ORB   = 6'd20, OP_ORCA  = 6'd21, OP_ORCB  = 6'd22;
   localparam logic [5:0] OP_ASLA  = 6'd23, OP_ASRA  = 6'd24, OP_JMP   = 6'd25;
   localparam logic [5:0] OP_BAEQ  = 6'd26, OP_BANE  = 6'd27, OP_BACS  = 6'd28;
   localparam logic [5:0] OP_BACC  = 6'd29, OP_BAMI  = 6'd30, OP_BAPL  = 6'd31;
   localparam logic [5:0] OP_BBEQ  = 6'd32, OP_BBNE  = 6'd33, OP_BBCS  = 6'd34;
   localparam logic [5:0] OP_BBCC  = 6'd35, OP_BBMI  = 6'd36, OP_BBPL  = 6'd37;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   // Slot 0 = EX, 1 = MEM, 2 = WB; each entry is {wA, wB}.
   logic [2:0][1:0]  sb_reg, sb_next;
   logic [1:0]       sb_in, id_dest;
   logic             reads_a, reads_b, hit_a, hit_b, raw, jmp;

   always_comb begin
      case (bus.id_opcode)
         OP_STA, OP_ADDA, OP_ADDB, OP_ADDCA, OP_SUBA, OP_SUBB, OP_SUBCA,
         OP_ANDA, OP_ANDB, OP_ANDCA, OP_ORA, OP_ORB, OP_ORCA, OP_ASLA, OP_ASRA,
         OP_BAEQ, OP_BANE, OP_BACS, OP_BACC, OP_BAMI, OP_BAPL:
            reads_a = 1'b1;
         default:
            reads_a = 1'b0;
      endcase
      case (bus.id_opcode)
         OP_STB, OP_ADDA, OP_ADDB, OP_ADDCB, OP_SUBA, OP_SUBB, OP_SUBCB,
         OP_ANDA, OP_ANDB, OP_ANDCB, OP_ORA, OP_ORB, OP_ORCB,
         OP_BBEQ, OP_BBNE, OP_BBCS, OP_BBCC, OP_BBMI, OP_BBPL:
            reads_b = 1'b1;
         default:
            reads_b = 1'b0;
      endcase
   end

   assign id_dest[1] = bus.id_valid && (bus.id_ctrl_acum == 3'b001 || bus.id_ctrl_acum == 3'b010);
   assign id_dest[0] = bus.id_valid && (bus.id_ctrl_acum == 3'b011 || bus.id_ctrl_acum == 3'b100);

   // No bypass network: any in-flight writer blocks a reader of the same accumulator.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      for (int i = 0; i < 3; i++) begin
         hit_a = hit_a | sb_reg[i][1];
         hit_b = hit_b | sb_reg[i][0];
      end
   end

   assign raw = bus.id_valid && ((reads_a && hit_a) || (reads_b && hit_b));
   assign jmp = bus.id_valid && (bus.id_opcode == OP_JMP);

   always_comb begin
      bus.pc_write     = 1'b1;
      bus.if_id_write  = 1'b1;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_bubble = 1'b0;
      sb_in            = id_dest;
      state_next       = RUN;
      if (reset) begin
         bus.pc_write     = 1'b0;
         bus.if_id_write  = 1'b0;
         bus.if_id_flush  = 1'b1;
         bus.id_ex_bubble = 1'b1;
      end else if (bus.mem_busy) begin
         bus.pc_write    = 1'b0;
         bus.if_id_write = 1'b0;
         state_next      = FREEZE;
      end else if (bus.ex_branch_taken) begin
         bus.if_id_flush  = 1'b1;
         bus.id_ex_bubble = 1'b1;
         sb_in            = 2'b00;
         state_next       = FLUSH;
      end else if (raw) begin
         bus.pc_write     = 1'b0;
         bus.if_id_write  = 1'b0;
         bus.id_ex_bubble = 1'b1;
         sb_in            = 2'b00;
         state_next       = RAW;
      end else if (jmp) begin
         bus.if_id_flush = 1'b1;
         sb_in           = 2'b00;
         state_next      = FLUSH;
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_sb
      if (gi == 0) begin : g_head
         assign sb_next[gi] = sb_in;
      end else begin : g_tail
         assign sb_next[gi] = sb_reg[gi-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sb_reg    <= '0;
         state_reg <= RUN;
         cnt_reg   <= '0;
      end else begin
         if (!bus.mem_busy)
            sb_reg <= sb_next;
         state_reg <= state_next;
         if (!bus.pc_write && cnt_reg != '1)
            cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign bus.stall_cnt = cnt_reg;
   assign bus.fsm_state = state_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and random checks of hazard_ctrl against a per-accumulator
// "cycles until free" model of the write scoreboard.
module tb_hazard_ctrl;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;

   localparam int NOP = 0, LDA = 1, LDB = 2, STA = 3, STB = 4, LDCA = 5, LDCB = 6;
   localparam int ADDA = 7, ADDB = 8, ADDCA = 9, ADDCB = 10, SUBA = 11, SUBB = 12;
   localparam int SUBCA = 13, SUBCB = 14, ANDA = 15, ANDB = 16, ANDCA = 17, ANDCB = 18;
   localparam int ORA = 19, ORB = 20, ORCA = 21, ORCB = 22, ASLA = 23, ASRA = 24, JMP = 25;
   localparam int ST_RUN = 0, ST_RAW = 1, ST_FLUSH = 2, ST_FREEZE = 3;

   int ra_list [21] = '{STA, ADDA, ADDB, ADDCA, SUBA, SUBB, SUBCA, ANDA, ANDB, ANDCA,
                        ORA, ORB, ORCA, ASLA, ASRA, 26, 27, 28, 29, 30, 31};
   int rb_list [19] = '{STB, ADDA, ADDB, ADDCB, SUBA, SUBB, SUBCB, ANDA, ANDB, ANDCB,
                        ORA, ORB, ORCB, 32, 33, 34, 35, 36, 37};
   bit ra_tab [64];
   bit rb_tab [64];

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass = 0;

   // Model state: advancing cycles left before each accumulator's last writer retires.
   int pend_a = 0, pend_b = 0, m_cnt = 0, m_state = ST_RUN;

   hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step(input bit r, input bit v, input int op, input int ca,
                       input bit br, input bit mb);
      bit ra, rb, wa, wb, raw, jmp, issue;
      bit e_pc, e_ifid, e_fl, e_bub;
      int e_next;
      @(negedge clk);
      reset               = r;
      bus.id_valid        = v;
      bus.id_opcode       = 6'(op);
      bus.id_ctrl_acum    = 3'(ca);
      bus.ex_branch_taken = br;
      bus.mem_busy        = mb;
      #1;
      ra    = ra_tab[op];
      rb    = rb_tab[op];
      raw   = v && ((ra && pend_a > 0) || (rb && pend_b > 0));
      jmp   = v && (op == JMP);
      wa    = v && (ca == 1 || ca == 2);
      wb    = v && (ca == 3 || ca == 4);
      issue = 1'b0;
      if (r)        begin e_pc = 0; e_ifid = 0; e_fl = 1; e_bub = 1; e_next = ST_RUN;    end
      else if (mb)  begin e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 0; e_next = ST_FREEZE; end
      else if (br)  begin e_pc = 1; e_ifid = 1; e_fl = 1; e_bub = 1; e_next = ST_FLUSH;  end
      else if (raw) begin e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1; e_next = ST_RAW;    end
      else if (jmp) begin e_pc = 1; e_ifid = 1; e_fl = 1; e_bub = 0; e_next = ST_FLUSH;  end
      else begin e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0; e_next = ST_RUN; issue = 1'b1; end
      $display("cyc rst=%0d v=%0d op=%0d ctrl=%0d br=%0d busy=%0d -> pc=%0d ifid=%0d fl=%0d bub=%0d cnt=%0d st=%0d",
               r, v, op, ca, br, mb, bus.pc_write, bus.if_id_write, bus.if_id_flush,
               bus.id_ex_bubble, bus.stall_cnt, bus.fsm_state);
      chk("pc_write",     32'(bus.pc_write),     32'(e_pc));
      chk("if_id_write",  32'(bus.if_id_write),  32'(e_ifid));
      chk("if_id_flush",  32'(bus.if_id_flush),  32'(e_fl));
      chk("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e_bub));
      chk("stall_cnt",    32'(bus.stall_cnt),    32'(m_cnt));
      chk("fsm_state",    32'(bus.fsm_state),    32'(m_state));
      if (r) begin
         pend_a = 0; pend_b = 0; m_cnt = 0; m_state = ST_RUN;
      end else begin
         if (!e_pc && m_cnt < CNT_MAX) m_cnt++;
         if (!mb) begin
            if (pend_a > 0) pend_a--;
            if (pend_b > 0) pend_b--;
            if (issue && wa) pend_a = 3;
            if (issue && wb) pend_b = 3;
         end
         m_state = e_next;
      end
   endtask

   task automatic probe_cnt(input string tag, input int exp);
      @(posedge clk);
      #1;
      chk(tag, 32'(bus.stall_cnt), 32'(exp));
   endtask

   initial begin
      foreach (ra_list[i]) ra_tab[ra_list[i]] = 1'b1;
      foreach (rb_list[i]) rb_tab[rb_list[i]] = 1'b1;
      reset = 1'b1;
      bus.id_valid = 0; bus.id_opcode = '0; bus.id_ctrl_acum = '0;
      bus.ex_branch_taken = 0; bus.mem_busy = 0;

      step(1, 0, NOP, 0, 0, 0);
      step(1, 1, ADDA, 1, 0, 0);

      // Back-to-back A writer and reader: 3 stalls then issue.
      step(0, 1, LDCA, 1, 0, 0);
      repeat (4) step(0, 1, ADDCA, 1, 0, 0);
      probe_cnt("raw3_stall_cnt", 3);

      // B writer does not block an A reader; B reader after one gap stalls 2.
      step(1, 0, NOP, 0, 0, 0);
      step(0, 1, LDCB, 3, 0, 0);
      step(0, 1, NOP, 0, 0, 0);
      step(0, 1, ADDCA, 1, 0, 0);
      probe_cnt("cross_acc_no_stall", 0);
      step(1, 0, NOP, 0, 0, 0);
      step(0, 1, LDCB, 3, 0, 0);
      step(0, 1, NOP, 0, 0, 0);
      repeat (3) step(0, 1, ADDCB, 3, 0, 0);
      probe_cnt("raw2_stall_cnt", 2);

      // JMP flushes without stalling.
      step(0, 1, JMP, 0, 0, 0);
      probe_cnt("jmp_cnt_unchanged", 2);

      // Taken branch overrides a RAW hazard in ID.
      step(1, 0, NOP, 0, 0, 0);
      step(0, 1, LDA, 1, 0, 0);
      step(0, 1, ADDA, 1, 1, 0);
      step(0, 0, NOP, 0, 0, 0);
      probe_cnt("branch_no_stall", 0);

      // mem_busy during a RAW stall stretches it to 7 cycles.
      step(1, 0, NOP, 0, 0, 0);
      step(0, 1, LDCA, 1, 0, 0);
      step(0, 1, ADDCA, 1, 0, 0);
      repeat (4) step(0, 1, ADDCA, 1, 0, 1);
      repeat (3) step(0, 1, ADDCA, 1, 0, 0);
      probe_cnt("freeze_raw_cnt", 7);

      // Reset mid-stall clears the scoreboard.
      step(1, 0, NOP, 0, 0, 0);
      step(0, 1, LDCA, 1, 0, 0);
      step(0, 1, ADDCA, 1, 0, 0);
      step(1, 1, ADDCA, 1, 0, 0);
      step(0, 1, ADDCA, 1, 0, 0);
      probe_cnt("reset_clears_sb", 0);

      // Counter saturation with a 4-bit counter.
      step(0, 1, LDCA, 1, 0, 0);
      repeat (20) step(0, 1, ADDCA, 1, 0, 1);
      probe_cnt("stall_cnt_saturates", 15);

      // Random traffic against the model.
      step(1, 0, NOP, 0, 0, 0);
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 9) != 0,
              int'($urandom_range(0, 63)),
              int'($urandom_range(0, 7)),
              $urandom_range(0, 11) == 0,
              $urandom_range(0, 7) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
